// File: rtl/prv_trap_sequencer.sv
// rtl/prv_trap_sequencer.sv - trap/return sequencer: prioritise events, wait for drain, commit CSR strobes and redirect
module prv_trap_sequencer #(
  parameter int NUM_EXTENSIONS   = 1,
  parameter int RMGMT_CAUSE_BASE = 24,
  localparam int CW = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          fault_insn,
  input  logic          mal_insn,
  input  logic          illegal_insn,
  input  logic          fault_l,
  input  logic          mal_l,
  input  logic          fault_s,
  input  logic          mal_s,
  input  logic          breakpoint,
  input  logic          env_m,
  input  logic          ex_rmgmt,
  input  logic [CW-1:0] ex_rmgmt_cause,
  input  logic          ret,
  input  logic [31:0]   epc,
  input  logic [31:0]   badaddr,
  input  logic          pipe_clear,
  input  logic          timer_int,
  input  logic          soft_int,
  input  logic          ext_int,
  input  logic [31:0]   mtvec,
  input  logic [31:0]   mepc_r,
  output logic          insert_pc,
  output logic [31:0]   priv_pc,
  output logic          intr,
  output logic          csr_we,
  output logic [31:0]   mepc_wdata,
  output logic [31:0]   mcause_wdata,
  output logic [31:0]   mtval_wdata,
  output logic          mstatus_push,
  output logic          mstatus_pop,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, WAIT_CLEAR, COMMIT} state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_INT, KIND_RET} kind_t;

  state_t      state, state_nxt;
  kind_t       cap_kind, ev_kind;
  logic [30:0] cap_code, ev_code;
  logic [31:0] cap_epc, cap_tval;
  logic        any_event, ev_tval_en;
  logic [31:0] trap_base;

  // Priority resolution: exceptions, then interrupts, then MRET.
  always_comb begin
    any_event  = 1'b1;
    ev_kind    = KIND_EXC;
    ev_code    = '0;
    ev_tval_en = 1'b1;
    if (breakpoint)        ev_code = 31'd3;
    else if (fault_insn)   ev_code = 31'd1;
    else if (illegal_insn) begin ev_code = 31'd2;  ev_tval_en = 1'b0; end
    else if (mal_insn)     ev_code = 31'd0;
    else if (env_m)        begin ev_code = 31'd11; ev_tval_en = 1'b0; end
    else if (mal_s)        ev_code = 31'd6;
    else if (mal_l)        ev_code = 31'd4;
    else if (fault_s)      ev_code = 31'd7;
    else if (fault_l)      ev_code = 31'd5;
    else if (ex_rmgmt) begin
      ev_code    = 31'(RMGMT_CAUSE_BASE) + 31'(ex_rmgmt_cause);
      ev_tval_en = 1'b0;
    end
    else if (ext_int)   begin ev_kind = KIND_INT; ev_code = 31'd11; ev_tval_en = 1'b0; end
    else if (soft_int)  begin ev_kind = KIND_INT; ev_code = 31'd3;  ev_tval_en = 1'b0; end
    else if (timer_int) begin ev_kind = KIND_INT; ev_code = 31'd7;  ev_tval_en = 1'b0; end
    else if (ret)       begin ev_kind = KIND_RET; ev_tval_en = 1'b0; end
    else begin
      any_event  = 1'b0;
      ev_tval_en = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cap_kind <= KIND_EXC;
      cap_code <= '0;
      cap_epc  <= '0;
      cap_tval <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_event) begin
        cap_kind <= ev_kind;
        cap_code <= ev_code;
        cap_epc  <= epc;
        cap_tval <= ev_tval_en ? badaddr : 32'd0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (any_event) state_nxt = WAIT_CLEAR;
      WAIT_CLEAR: if (pipe_clear) state_nxt = COMMIT;
      COMMIT:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign trap_base = {mtvec[31:2], 2'b00};

  always_comb begin
    insert_pc    = 1'b0;
    priv_pc      = '0;
    intr         = 1'b0;
    csr_we       = 1'b0;
    mepc_wdata   = '0;
    mcause_wdata = '0;
    mtval_wdata  = '0;
    mstatus_push = 1'b0;
    mstatus_pop  = 1'b0;
    busy         = (state != IDLE);
    if (state == COMMIT) begin
      insert_pc = 1'b1;
      case (cap_kind)
        KIND_RET: begin
          mstatus_pop = 1'b1;
          priv_pc     = mepc_r;
        end
        KIND_INT: begin
          intr         = 1'b1;
          csr_we       = 1'b1;
          mstatus_push = 1'b1;
          priv_pc      = (mtvec[1:0] == 2'b01) ? trap_base + {cap_code[29:0], 2'b00} : trap_base;
        end
        default: begin
          csr_we       = 1'b1;
          mstatus_push = 1'b1;
          priv_pc      = trap_base;
        end
      endcase
      if (csr_we) begin
        mepc_wdata   = {cap_epc[31:2], 2'b00};
        mcause_wdata = {cap_kind == KIND_INT, cap_code};
        mtval_wdata  = cap_tval;
      end
    end
  end

endmodule
